// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes the A/B phases, primes its history for
// two cycles after reset, then counts legal Gray-code steps up or down and
// flags transitions where both phases changed at once.
module quad_decoder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic [WIDTH-1:0] position,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic             err_sticky
);

  typedef enum logic [1:0] {
    PRIME0 = 2'd0,
    PRIME1 = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       s1_q, s1_d;
  logic [1:0]       s2_q, s2_d;
  logic [1:0]       prev_q, prev_d;
  logic [WIDTH-1:0] position_q, position_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic             err_sticky_q, err_sticky_d;
  logic             up, down, illegal;

  // Next-state, decode and output computation.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    s1_d         = {a, b};
    s2_d         = s1_q;
    state_d      = state_q;
    prev_d       = prev_q;
    position_d   = position_q;
    step_d       = 1'b0;
    dir_d        = dir_q;
    err_d        = 1'b0;
    up           = 1'b0;
    down         = 1'b0;
    illegal      = 1'b0;

    case (state_q)
      PRIME0: state_d = PRIME1;
      PRIME1: begin
        state_d = RUN;
        // s1 is what s2 becomes on this edge, so prev matches s2 on the
        // first RUN cycle and a static input never looks like a transition.
        prev_d  = s1_q;
      end
      RUN: begin
        prev_d = s2_q;
        case ({prev_q, s2_q})
          4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: up      = 1'b1;
          4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: down    = 1'b1;
          4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal = 1'b1;
          default: ;
        endcase
      end
      default: state_d = PRIME0;
    endcase

    if (up) begin
      position_d = position_q + WIDTH'(1);
      step_d     = 1'b1;
      dir_d      = 1'b0;
    end else if (down) begin
      position_d = position_q - WIDTH'(1);
      step_d     = 1'b1;
      dir_d      = 1'b1;
    end else if (illegal) begin
      err_d      = 1'b1;
    end

    // Clear overrides the count and the sticky flag but not the pulses.
    if (clr) position_d = '0;
    err_sticky_d = clr ? 1'b0 : (err_sticky_q | err_d);
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= PRIME0;
      s1_q         <= 2'b00;
      s2_q         <= 2'b00;
      prev_q       <= 2'b00;
      position_q   <= '0;
      step_q       <= 1'b0;
      dir_q        <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // which is what makes s1 -> s2 a real two-stage synchronizer.
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      prev_q       <= prev_d;
      position_q   <= position_d;
      step_q       <= step_d;
      dir_q        <= dir_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign position   = position_q;
  assign step       = step_q;
  assign dir        = dir_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Testbench for quad_decoder: a vector table of phase levels with expected
// outputs, plus hand-written reset sequences.
module tb_quad_decoder;

  logic       clk, rst, a, b, clr;
  logic [3:0] position;
  logic       step, dir, err, err_sticky;
  int         total = 0;
  int         bad   = 0;

  typedef struct {
    logic [1:0] ab;
    logic       clr;
    logic [3:0] pos;
    logic       step;
    logic       dir;
    logic       err;
    logic       sticky;
  } vec_t;

  vec_t vecs[$];

  quad_decoder #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .clr        (clr),
    .position   (position),
    .step       (step),
    .dir        (dir),
    .err        (err),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [1:0] ab, input logic c, input logic [3:0] p,
                     input logic s, input logic d, input logic e, input logic sk);
    vec_t v;
    v.ab = ab; v.clr = c; v.pos = p; v.step = s; v.dir = d; v.err = e; v.sticky = sk;
    vecs.push_back(v);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pos"},    32'(position),   32'h0);
    check({tag, "_pulses"}, {30'd0, step, err}, 32'h0);
    check({tag, "_dir"},    32'(dir),        32'h0);
    check({tag, "_sticky"}, 32'(err_sticky), 32'h0);
  endtask

  initial begin
    logic [1:0] fwd[4];
    fwd = '{2'b01, 2'b11, 2'b10, 2'b00};

    // 16 forward steps from 00, wrapping 15 -> 0.
    for (int i = 0; i < 16; i++) add(fwd[i % 4], 1'b0, 4'((i + 1) % 16), 1, 0, 0, 0);
    add(2'b10, 0, 4'hF, 1, 1, 0, 0); // reverse 00->10, 0 - 1 wraps
    add(2'b00, 0, 4'h0, 1, 0, 0, 0); // 10->00 up
    add(2'b11, 0, 4'h0, 0, 0, 1, 1); // 00->11 illegal
    add(2'b10, 0, 4'h1, 1, 0, 0, 1); // 11->10 up after error
    add(2'b00, 0, 4'h2, 1, 0, 0, 1);
    add(2'b01, 0, 4'h3, 1, 0, 0, 1);
    add(2'b11, 0, 4'h4, 1, 0, 0, 1);
    add(2'b10, 0, 4'h5, 1, 0, 0, 1);
    add(2'b00, 1, 4'h0, 1, 0, 0, 0); // up step with clr at position 5
    add(2'b10, 0, 4'hF, 1, 1, 0, 0); // down wraps to F
    add(2'b10, 0, 4'hF, 0, 1, 0, 0); // no change holds
    add(2'b01, 0, 4'hF, 0, 1, 1, 1); // 10->01 illegal, dir held
    add(2'b10, 1, 4'h0, 0, 1, 1, 0); // illegal with clr: sticky stays clear
    add(2'b11, 0, 4'hF, 1, 1, 0, 0); // 10->11 down

    // Reset with both phases high, held across release.
    rst = 1'b0; a = 1'b1; b = 1'b1; clr = 1'b0;
    #3;
    check_reset_vals("rst_async");
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("rel11_quiet%0d", i), {30'd0, step, err}, 32'h0);
    end
    check_reset_vals("rel11_end");

    // Re-reset with phases at 00 and let the priming finish.
    a = 1'b0; b = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_reset_vals("run00");

    // Table: each level is held 4 cycles; effect lands on the third edge.
    for (int i = 0; i < vecs.size(); i++) begin
      {a, b} = vecs[i].ab;
      tick(); tick();
      check($sformatf("v%0d_early", i), {30'd0, step, err}, 32'h0);
      clr = vecs[i].clr;
      tick();
      clr = 1'b0;
      check($sformatf("v%0d_pos", i),    32'(position),   32'(vecs[i].pos));
      check($sformatf("v%0d_step", i),   32'(step),       32'(vecs[i].step));
      check($sformatf("v%0d_dir", i),    32'(dir),        32'(vecs[i].dir));
      check($sformatf("v%0d_err", i),    32'(err),        32'(vecs[i].err));
      check($sformatf("v%0d_sticky", i), 32'(err_sticky), 32'(vecs[i].sticky));
      tick();
      check($sformatf("v%0d_pulse_end", i), {30'd0, step, err}, 32'h0);
    end

    // Reset pulse two edges after an input change aborts the pending step.
    {a, b} = 2'b01;
    tick(); tick();
    rst = 1'b0;
    #1;
    check_reset_vals("abort_async");
    tick();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("abort_quiet%0d", i), {30'd0, step, err}, 32'h0);
    end
    check_reset_vals("abort_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
